// File: rtl/level_sensor_conditioner.sv
// Float-switch front end: 2-flop sync, per-bit debounce, thermometer check, INIT/TRACK/FAULT control.
// Optional LEVEL_STEP_EN: s moves at most one thermometer step per edge while tracking.
module level_sensor_conditioner #(
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned FAULT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] raw,
    input  logic       fault_clr,
    output logic [2:0] s,
    output logic       s_valid,
    output logic       fault
);

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [7:0] FC_LIMIT = 8'(FAULT_CYCLES);
    localparam logic [8:0] INIT_SAT = 9'(DEBOUNCE + 2);

    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

    state_t     state;
    logic [2:0] sync1, sync2, deb;
    logic [7:0] cnt [3];
    logic [7:0] fcnt, fcnt_inc;
    logic [8:0] init_cnt;
    logic       init_sat;
    logic       pat_valid, cnts_zero;
    logic [2:0] s_track;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        deb[i] <= ~deb[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        pat_valid = (deb == 3'b000) || (deb == 3'b001) || (deb == 3'b011) || (deb == 3'b111);
        cnts_zero = (cnt[0] == 8'd0) && (cnt[1] == 8'd0) && (cnt[2] == 8'd0);
        fcnt_inc  = (fcnt == 8'hFF) ? fcnt : fcnt + 8'd1;
`ifdef LEVEL_STEP_EN
        // Thermometer codes order correctly as unsigned values, so a magnitude compare picks the direction.
        if (deb > s)
            s_track = {s[1:0], 1'b1};
        else if (deb < s)
            s_track = {1'b0, s[2:1]};
        else
            s_track = s;
`else
        s_track = deb;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            s        <= '0;
            s_valid  <= 1'b0;
            fault    <= 1'b0;
            fcnt     <= '0;
            init_cnt <= '0;
            init_sat <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    s       <= '0;
                    s_valid <= 1'b0;
                    if (init_cnt != INIT_SAT)
                        init_cnt <= init_cnt + 9'd1;
                    else
                        init_sat <= 1'b1;
                    // Saturation is registered, so the exit decision lands one edge after the count tops out.
                    if (init_sat) begin
                        if (pat_valid) begin
                            fcnt <= '0;
                            if (cnts_zero) begin
                                state   <= TRACK;
                                s       <= deb;
                                s_valid <= 1'b1;
                            end
                        end else begin
                            fcnt <= fcnt_inc;
                            if (fcnt_inc == FC_LIMIT) begin
                                state <= FAULT;
                                fault <= 1'b1;
                            end
                        end
                    end
                end
                TRACK: begin
                    if (pat_valid) begin
                        s    <= s_track;
                        fcnt <= '0;
                    end else begin
                        fcnt <= fcnt_inc;
                        if (fcnt_inc == FC_LIMIT) begin
                            state   <= FAULT;
                            fault   <= 1'b1;
                            s_valid <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clr && pat_valid) begin
                        state   <= TRACK;
                        s       <= deb;
                        fault   <= 1'b0;
                        s_valid <= 1'b1;
                        fcnt    <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner (DEBOUNCE=4, FAULT_CYCLES=8); honours LEVEL_STEP_EN.
module tb_level_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] raw;
    logic       fault_clr;
    logic [2:0] s;
    logic       s_valid;
    logic       fault;

    int unsigned tests = 0;
    int unsigned fails = 0;

    level_sensor_conditioner #(.DEBOUNCE(4), .FAULT_CYCLES(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (raw),
        .fault_clr(fault_clr),
        .s        (s),
        .s_valid  (s_valid),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        raw       = 3'b000;
        fault_clr = 1'b0;
        #12;
        check("rst_s", s, 3'b000);
        check("rst_valid", {2'b0, s_valid}, 3'd0);
        check("rst_fault", {2'b0, fault}, 3'd0);

        tick(1);
        reset_n = 1'b1;
        tick(7);
        check("init_valid_e7", {2'b0, s_valid}, 3'd0);
        tick(1);
        check("init_valid_e8", {2'b0, s_valid}, 3'd1);
        check("init_s", s, 3'b000);
        check("init_fault", {2'b0, fault}, 3'd0);

        raw = 3'b001;
        tick(6);
        check("step1_e6", s, 3'b000);
        tick(1);
        check("step1_e7", s, 3'b001);
        tick(4);

        raw = 3'b011;
        tick(3);
        raw = 3'b001;
        for (int unsigned k = 0; k < 10; k++) begin
            check("glitch_hold", s, 3'b001);
            tick(1);
        end

        raw = 3'b101;
        tick(13);
        check("bad_e13_fault", {2'b0, fault}, 3'd0);
        check("bad_e13_valid", {2'b0, s_valid}, 3'd1);
        tick(1);
        check("bad_e14_fault", {2'b0, fault}, 3'd1);
        check("bad_e14_valid", {2'b0, s_valid}, 3'd0);
        check("bad_e14_s", s, 3'b001);

        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("clr_invalid_fault", {2'b0, fault}, 3'd1);

        raw = 3'b111;
        tick(9);
        check("settle_fault", {2'b0, fault}, 3'd1);
        check("settle_s", s, 3'b001);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("clr_s", s, 3'b111);
        check("clr_fault", {2'b0, fault}, 3'd0);
        check("clr_valid", {2'b0, s_valid}, 3'd1);

        raw = 3'b000;
        tick(12);
        check("down_s", s, 3'b000);

        raw = 3'b111;
        tick(6);
        check("jump_e6", s, 3'b000);
        tick(1);
`ifdef LEVEL_STEP_EN
        check("jump_e7", s, 3'b001);
        tick(1);
        check("jump_e8", s, 3'b011);
        tick(1);
        check("jump_e9", s, 3'b111);
`else
        check("jump_e7", s, 3'b111);
        tick(1);
        check("jump_e8", s, 3'b111);
`endif
        tick(3);

        raw = 3'b001;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_s", s, 3'b000);
        check("midrst_valid", {2'b0, s_valid}, 3'd0);
        check("midrst_fault", {2'b0, fault}, 3'd0);
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check("midrst_init_valid", {2'b0, s_valid}, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/level_sensor_conditioner.md
Name: level_sensor_conditioner

Overview:
- Front-end stage for the reservoir flow-rate controller. It drives that controller's s[3:1] sensor input.
- Takes the three raw, asynchronous float-switch lines and synchronises them, debounces each bit, and checks for a consistent thermometer level code.
- Delivers a clean, glitch-free s[3:1] plus validity and fault flags.
- On a sensor inconsistency it holds the last good level, so the controller never sees an impossible sensor pattern.

Parameters:
- DEBOUNCE, 4: consecutive sampled cycles a synchronised bit must differ from its debounced value before the debounced value flips. Legal range 2..255.
- FAULT_CYCLES, 8: consecutive cycles of an invalid debounced pattern before FAULT is entered. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- raw  input  3  raw float switches. Bit 0 = lowest sensor (s[1]). Asynchronous to clk.
- fault_clr  input  1  single-cycle request to leave FAULT.
- s  output  3  conditioned level to the controller. Legal values 000, 001, 011, 111.
- s_valid  output  1  high when s reflects tracked sensor state.
- fault  output  1  high while in FAULT.

Behaviour:
- Reset (reset_n low, asynchronous): sync flops = 0, debounced = 000, debounce counters = 0, s = 000, s_valid = 0, fault = 0, fault counter = 0, init counter = 0, state INIT.
- Synchroniser: two flops per bit. raw is visible at sync2 two edges after it changes.
- Debounce, per bit:
  - If sync2 != deb: cnt increments. When cnt == DEBOUNCE-1 and sync2 still != deb, deb flips on that edge and cnt clears.
  - If sync2 == deb: cnt clears.
- Pattern check: combinational. The debounced pattern is valid iff it is 000, 001, 011 or 111.
- State INIT:
  - s = 000, s_valid = 0.
  - Init counter runs 0..DEBOUNCE+2 and saturates.
  - At saturation, with the pattern valid and all debounce counters 0: next edge goes to TRACK, loads s from deb, and sets s_valid = 1.
  - At saturation with the pattern invalid: the fault counter runs exactly as in TRACK.
- State TRACK:
  - Each edge with a valid pattern: s <= deb, fault counter <= 0.
  - Each edge with an invalid pattern: s holds, fault counter increments.
  - When the counter reaches FAULT_CYCLES, go to FAULT on that edge: fault = 1, s_valid = 0, s held.
- State FAULT:
  - s holds its last value.
  - fault_clr sampled high with a valid pattern: go to TRACK, s <= deb, fault = 0, s_valid = 1, fault counter = 0, all on the same edge.
  - fault_clr with an invalid pattern is ignored and the block stays in FAULT.
- Latency: a clean raw level step reaches s at edge 2 + DEBOUNCE + 1, counting edge 1 as the first edge after the change. With DEBOUNCE = 4 that is the 7th edge.
- Glitches: a raw pulse shorter than DEBOUNCE cycles after synchronisation never reaches s.
- Simultaneous events:
  - A debounce flip and a pattern check in the same cycle: the check uses pre-flip deb. The new value is seen on the next edge.
  - fault_clr in INIT or TRACK: no effect.
- Mid-operation reset: asynchronous return to the reset values. No pending counts survive.
- All counters saturate and never wrap.

Optional Feature:
- Macro: LEVEL_STEP_EN.
- Defined: in TRACK, s moves at most one thermometer step per edge toward deb (000 -> 001 -> 011 -> 111 and the reverse). This prevents a multi-level jump at the controller.
  - Loads on INIT exit and on FAULT exit are still direct.
- Undefined: s <= deb directly in TRACK.

Test Plan:
- Reset then raw = 000 constant: s_valid rises on the 8th edge after reset release (with DEBOUNCE = 4). s = 000, fault = 0.
- In TRACK, raw 000 -> 001: s = 001 on the 7th edge after the change. No change before that edge.
- In TRACK with s = 001, 3-cycle raw pulse 001 -> 011 -> 001: s stays 001 throughout.
- In TRACK, raw = 101 held: fault = 1 and s_valid = 0 eight edges after deb becomes 101. s stays at its prior value (001).
  - Then fault_clr pulse while still 101: fault stays 1.
  - Then raw = 111 settles and a fault_clr pulse follows: s = 111, fault = 0, s_valid = 1 on the same edge.
- reset_n asserted mid-debounce (raw just changed): outputs go to reset values immediately, without waiting for a clock edge.
- LEVEL_STEP_EN defined, s = 000, raw -> 111: s steps 001, 011, 111 on consecutive edges once deb = 111.
